// File: rtl/riscv_defines.sv
// ---------------------------------------------------------------------------
// riscv_defines
// Shared constants and types for the memory stage.
//   WORD_WIDTH    : datapath width
//   ADDR_WIDTH    : register-file address width
//   mem_size_e    : access size (BYTE, HALF, WORD)
//   decode_size   : maps the raw 2-bit size field to mem_size_e (11 -> WORD)
//   is_misaligned : alignment check for a given size and byte offset
// ---------------------------------------------------------------------------
package riscv_defines;

  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic mem_size_e decode_size(input logic [1:0] raw);
    mem_size_e size;
    case (raw)
      2'b00:   size = BYTE;
      2'b01:   size = HALF;
      default: size = WORD;
    endcase
    return size;
  endfunction

  // Bytes are always aligned; halves need offset[0]==0; words need offset==0.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] offset);
    logic mis;
    case (size)
      HALF:    mis = offset[0];
      WORD:    mis = (offset != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/data_align.sv
// ---------------------------------------------------------------------------
// data_align
// Purely combinational bus formatting for the memory stage.
//   offset      in  2   byte offset inside the addressed word (addr[1:0])
//   size        in  2   access size
//   is_unsigned in  1   zero-extend loads instead of sign-extend
//   store_data  in  32  raw store data (rs2)
//   rdata       in  32  raw bus read data
//   be          out 4   byte enables for the access
//   wdata       out 32  store data replicated across the word
//   load_data   out 32  extracted and extended load result
// ---------------------------------------------------------------------------
module data_align
  import riscv_defines::*;
(
  input  logic [1:0]            offset,
  input  mem_size_e             size,
  input  logic                  is_unsigned,
  input  logic [WORD_WIDTH-1:0] store_data,
  input  logic [WORD_WIDTH-1:0] rdata,
  output logic [3:0]            be,
  output logic [WORD_WIDTH-1:0] wdata,
  output logic [WORD_WIDTH-1:0] load_data
);

  logic [WORD_WIDTH-1:0] shifted;
  logic                  byte_sign;
  logic                  half_sign;

  // Store side: replicating the data into every lane lets the byte enables
  // alone select which lanes the memory actually writes.
  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    case (size)
      BYTE: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      HALF: begin
        be    = 4'b0011 << {offset[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  // Load side: move the addressed lane down to bit 0, then extend.
  assign shifted   = rdata >> {offset, 3'b000};
  assign byte_sign = ~is_unsigned & shifted[7];
  assign half_sign = ~is_unsigned & shifted[15];

  always_comb begin
    load_data = shifted;
    case (size)
      BYTE:    load_data = {{(WORD_WIDTH-8){byte_sign}}, shifted[7:0]};
      HALF:    load_data = {{(WORD_WIDTH-16){half_sign}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Pipeline memory stage with a single-outstanding request/grant/rvalid bus.
//   clk_i, rst_i                  clock (rising edge), async active-high reset
//   ex_valid_i / ex_ready_o       handshake from EX; ready only when idle
//   alu_result_i                  ALU result or effective address
//   store_data_i                  rs2 data for stores
//   reg_waddr_i, reg_we_i         destination register and write request
//   mem_read_i, mem_write_i       load / store (both set -> load)
//   mem_size_i, mem_unsigned_i    access size (11 -> word), zero-extend load
//   data_req_o / data_gnt_i       bus request / grant
//   data_addr_o, data_we_o,
//   data_be_o, data_wdata_o       word-aligned bus address, write, lanes, data
//   data_rvalid_i, data_rdata_i   bus response
//   wb_valid_o, wb_data_o,
//   wb_waddr_o, wb_we_o           registered one-cycle writeback
//   misaligned_o                  one-cycle pulse for a rejected access
// ---------------------------------------------------------------------------
module mem_stage
  import riscv_defines::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ex_valid_i,
  output logic                  ex_ready_o,
  input  logic [WORD_WIDTH-1:0] alu_result_i,
  input  logic [WORD_WIDTH-1:0] store_data_i,
  input  logic [ADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                  reg_we_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [1:0]            mem_size_i,
  input  logic                  mem_unsigned_i,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [WORD_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [WORD_WIDTH-1:0] data_wdata_o,
  input  logic                  data_rvalid_i,
  input  logic [WORD_WIDTH-1:0] data_rdata_i,
  output logic                  wb_valid_o,
  output logic [WORD_WIDTH-1:0] wb_data_o,
  output logic [ADDR_WIDTH-1:0] wb_waddr_o,
  output logic                  wb_we_o,
  output logic                  misaligned_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RVALID
  } state_e;

  state_e state_reg, state_next;

  // Operation captured at the EX handshake.
  logic [WORD_WIDTH-1:0] addr_reg;
  logic [WORD_WIDTH-1:0] store_data_reg;
  logic [ADDR_WIDTH-1:0] waddr_reg;
  logic                  reg_we_reg;
  logic                  load_reg;
  logic                  store_reg;
  logic                  unsigned_reg;
  mem_size_e             size_reg;

  // Writeback registers.
  logic                  wb_valid_reg, wb_valid_next;
  logic [WORD_WIDTH-1:0] wb_data_reg,  wb_data_next;
  logic [ADDR_WIDTH-1:0] wb_waddr_reg, wb_waddr_next;
  logic                  wb_we_reg,    wb_we_next;
  logic                  misaligned_reg, misaligned_next;

  logic                  accept;
  logic                  in_mem;
  logic                  in_misaligned;
  logic [3:0]            be;
  logic [WORD_WIDTH-1:0] wdata;
  logic [WORD_WIDTH-1:0] load_data;

  assign accept        = ex_valid_i && (state_reg == IDLE);
  assign in_mem        = mem_read_i || mem_write_i;
  // Alignment is judged on the live inputs so a bad access never leaves IDLE.
  assign in_misaligned = in_mem && is_misaligned(decode_size(mem_size_i), alu_result_i[1:0]);

  // -------------------------------------------------------------------------
  // Operation capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_reg       <= '0;
      store_data_reg <= '0;
      waddr_reg      <= '0;
      reg_we_reg     <= 1'b0;
      load_reg       <= 1'b0;
      store_reg      <= 1'b0;
      unsigned_reg   <= 1'b0;
      size_reg       <= BYTE;
    end else if (accept) begin
      addr_reg       <= alu_result_i;
      store_data_reg <= store_data_i;
      waddr_reg      <= reg_waddr_i;
      reg_we_reg     <= reg_we_i;
      // A request flagged as both read and write is handled as a load.
      load_reg       <= mem_read_i;
      store_reg      <= mem_write_i && !mem_read_i;
      unsigned_reg   <= mem_unsigned_i;
      size_reg       <= decode_size(mem_size_i);
    end
  end

  // -------------------------------------------------------------------------
  // Lane formatting for both directions
  // -------------------------------------------------------------------------
  data_align u_data_align (
    .offset      (addr_reg[1:0]),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .store_data  (store_data_reg),
    .rdata       (data_rdata_i),
    .be          (be),
    .wdata       (wdata),
    .load_data   (load_data)
  );

  // -------------------------------------------------------------------------
  // FSM state and writeback registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      wb_valid_reg   <= 1'b0;
      wb_data_reg    <= '0;
      wb_waddr_reg   <= '0;
      wb_we_reg      <= 1'b0;
      misaligned_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wb_valid_reg   <= wb_valid_next;
      wb_data_reg    <= wb_data_next;
      wb_waddr_reg   <= wb_waddr_next;
      wb_we_reg      <= wb_we_next;
      misaligned_reg <= misaligned_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and writeback generation
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    wb_valid_next   = 1'b0;
    wb_data_next    = wb_data_reg;
    wb_waddr_next   = wb_waddr_reg;
    wb_we_next      = 1'b0;
    misaligned_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (!in_mem) begin
            // ALU result bypasses the bus entirely.
            wb_valid_next = 1'b1;
            wb_data_next  = alu_result_i;
            wb_waddr_next = reg_waddr_i;
            wb_we_next    = reg_we_i && (reg_waddr_i != '0);
          end else if (in_misaligned) begin
            // Retire immediately with the register write suppressed.
            wb_valid_next   = 1'b1;
            wb_data_next    = alu_result_i;
            wb_waddr_next   = reg_waddr_i;
            misaligned_next = 1'b1;
          end else begin
            state_next = REQ;
          end
        end
      end

      REQ: begin
        if (data_gnt_i) begin
          state_next = WAIT_RVALID;
        end
      end

      WAIT_RVALID: begin
        if (data_rvalid_i) begin
          state_next    = IDLE;
          wb_valid_next = 1'b1;
          wb_waddr_next = waddr_reg;
          wb_data_next  = load_reg ? load_data : addr_reg;
          wb_we_next    = load_reg && reg_we_reg && (waddr_reg != '0);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign ex_ready_o   = (state_reg == IDLE);
  assign data_req_o   = (state_reg == REQ);
  assign data_we_o    = (state_reg == REQ) && store_reg;
  // Lanes are only meaningful while requesting; this also keeps them zero
  // out of reset even though a zero offset would decode to lane 0.
  assign data_be_o    = (state_reg == REQ) ? be : 4'b0000;
  assign data_addr_o  = {addr_reg[WORD_WIDTH-1:2], 2'b00};
  assign data_wdata_o = wdata;

  assign wb_valid_o   = wb_valid_reg;
  assign wb_data_o    = wb_data_reg;
  assign wb_waddr_o   = wb_waddr_reg;
  assign wb_we_o      = wb_we_reg;
  assign misaligned_o = misaligned_reg;

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic        ex_ready_o;
  logic [31:0] alu_result_i = '0;
  logic [31:0] store_data_i = '0;
  logic [4:0]  reg_waddr_i = '0;
  logic        reg_we_i = 1'b0;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [1:0]  mem_size_i = '0;
  logic        mem_unsigned_i = 1'b0;
  logic        data_req_o;
  logic        data_gnt_i = 1'b0;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        wb_valid_o;
  logic [31:0] wb_data_o;
  logic [4:0]  wb_waddr_o;
  logic        wb_we_o;
  logic        misaligned_o;

  always #5 clk_i = ~clk_i;

  mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_addr_o(data_addr_o), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
    .wb_waddr_o(wb_waddr_o), .wb_we_o(wb_we_o),
    .misaligned_o(misaligned_o)
  );

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] alu, sdata;
    logic [4:0]  rd_addr;
    logic        we;
    int          gnt_dly, rv_dly;
    logic [31:0] rdata;
  } op_t;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        bus_we;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        mis;
    logic        chk_data;
  } exp_t;

  typedef struct {
    int          wb_pulses, wb_first, req_cycles;
    logic [31:0] wb_data;
    logic [4:0]  wb_waddr;
    logic        wb_we, mis;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        bus_we, unstable, ready_hi, req_late;
  } res_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  int total = 0;
  int bad = 0;

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", what, act, exp);
    end
  endtask

  function automatic op_t mk_op(input logic rd, input logic wr, input logic [1:0] size,
                                input logic uns, input logic [31:0] alu, input logic [31:0] sdata,
                                input logic [4:0] rda, input logic we, input int g, input int v,
                                input logic [31:0] rdata);
    op_t o;
    o.rd = rd; o.wr = wr; o.size = size; o.uns = uns; o.alu = alu; o.sdata = sdata;
    o.rd_addr = rda; o.we = we; o.gnt_dly = g; o.rv_dly = v; o.rdata = rdata;
    return o;
  endfunction

  function automatic exp_t mk_exp(input logic req, input logic [31:0] addr, input logic [3:0] be,
                                  input logic [31:0] wdata, input logic bus_we,
                                  input logic [31:0] wb_data, input logic wb_we,
                                  input logic mis, input logic chk);
    exp_t e;
    e.req = req; e.addr = addr; e.be = be; e.wdata = wdata; e.bus_we = bus_we;
    e.wb_data = wb_data; e.wb_we = wb_we; e.mis = mis; e.chk_data = chk;
    return e;
  endfunction

  // Reference model: derived from access size in bytes and byte offset.
  function automatic exp_t model(input op_t op);
    exp_t        e;
    int          nbytes, off;
    logic [31:0] v, mask;
    nbytes = (op.size == 2'd0) ? 1 : (op.size == 2'd1) ? 2 : 4;
    off    = int'(op.alu % 4);
    e.mis  = (op.rd || op.wr) && ((off % nbytes) != 0);
    e.req  = (op.rd || op.wr) && !e.mis;
    e.addr = op.alu - 32'(off);
    e.be   = 4'b0000;
    for (int i = 0; i < nbytes; i++)
      if (off + i < 4) e.be[off + i] = 1'b1;
    for (int i = 0; i < 4; i++)
      e.wdata[8*i +: 8] = op.sdata[8*(i % nbytes) +: 8];
    e.bus_we = op.wr && !op.rd;
    v = op.rdata >> (8 * off);
    if (nbytes < 4) begin
      mask = (32'h1 << (8 * nbytes)) - 32'h1;
      v = v & mask;
      if (!op.uns && v[8*nbytes-1]) v = v | ~mask;
    end
    e.wb_data = 32'h0; e.wb_we = 1'b0; e.chk_data = 1'b0;
    if (!(op.rd || op.wr)) begin
      e.wb_data = op.alu; e.chk_data = 1'b1; e.wb_we = op.we && (op.rd_addr != 0);
    end else if (!e.mis && op.rd) begin
      e.wb_data = v; e.chk_data = 1'b1; e.wb_we = op.we && (op.rd_addr != 0);
    end
    return e;
  endfunction

  task automatic drive_ex(input op_t op);
    alu_result_i = op.alu; store_data_i = op.sdata; reg_waddr_i = op.rd_addr;
    reg_we_i = op.we; mem_read_i = op.rd; mem_write_i = op.wr;
    mem_size_i = op.size; mem_unsigned_i = op.uns;
  endtask

  // Issues one op and plays the bus slave; records everything observed.
  task automatic run_op(input op_t op, output res_t r);
    int ph, wait_cnt, budget;
    r.wb_pulses = 0; r.wb_first = -1; r.req_cycles = 0; r.wb_data = '0; r.wb_waddr = '0;
    r.wb_we = 1'b0; r.mis = 1'b0; r.addr = '0; r.wdata = '0; r.be = '0; r.bus_we = 1'b0;
    r.unstable = 1'b0; r.ready_hi = 1'b0; r.req_late = 1'b0;
    ph = 0; wait_cnt = 0;
    budget = op.gnt_dly + op.rv_dly + 8;
    @(posedge clk_i); #1;
    drive_ex(op);
    ex_valid_i = 1'b1;
    @(posedge clk_i); #1;
    ex_valid_i = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_i);
      data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = $urandom();
      if (wb_valid_o) begin
        if (r.wb_pulses == 0) begin
          r.wb_first = c; r.wb_data = wb_data_o; r.wb_waddr = wb_waddr_o;
          r.wb_we = wb_we_o; r.mis = misaligned_o;
        end
        r.wb_pulses++;
      end
      if (data_req_o) begin
        if (ph != 0) r.req_late = 1'b1;
        else begin
          if (r.req_cycles == 0) begin
            r.addr = data_addr_o; r.be = data_be_o; r.wdata = data_wdata_o; r.bus_we = data_we_o;
          end else if (r.addr !== data_addr_o || r.be !== data_be_o ||
                       r.wdata !== data_wdata_o || r.bus_we !== data_we_o) begin
            r.unstable = 1'b1;
          end
          if (ex_ready_o) r.ready_hi = 1'b1;
          if (r.req_cycles == op.gnt_dly) begin
            data_gnt_i = 1'b1; ph = 1;
          end else begin
            data_rvalid_i = 1'($urandom_range(0, 1));  // must be ignored in REQ
          end
          r.req_cycles++;
        end
      end else if (ph == 1) begin
        if (ex_ready_o) r.ready_hi = 1'b1;
        if (wait_cnt == op.rv_dly) begin
          data_rvalid_i = 1'b1; data_rdata_i = op.rdata; ph = 2;
        end
        wait_cnt++;
      end
    end
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
  endtask

  task automatic compare(input string tag, input op_t op, input exp_t e, input res_t r);
    check({tag, "_req"}, 32'(r.req_cycles > 0), 32'(e.req));
    if (e.req) begin
      check({tag, "_addr"}, r.addr, e.addr);
      check({tag, "_be"}, 32'(r.be), 32'(e.be));
      check({tag, "_bus_we"}, 32'(r.bus_we), 32'(e.bus_we));
      if (e.bus_we) check({tag, "_wdata"}, r.wdata, e.wdata);
      check({tag, "_req_cycles"}, r.req_cycles, op.gnt_dly + 1);
      check({tag, "_stable"}, 32'(r.unstable), 32'h0);
      check({tag, "_ready_low"}, 32'(r.ready_hi), 32'h0);
      check({tag, "_req_drop"}, 32'(r.req_late), 32'h0);
    end else begin
      check({tag, "_latency"}, r.wb_first, 0);
    end
    check({tag, "_wb_pulses"}, r.wb_pulses, 1);
    check({tag, "_wb_we"}, 32'(r.wb_we), 32'(e.wb_we));
    check({tag, "_mis"}, 32'(r.mis), 32'(e.mis));
    check({tag, "_wb_waddr"}, 32'(r.wb_waddr), 32'(op.rd_addr));
    if (e.chk_data) check({tag, "_wb_data"}, r.wb_data, e.wb_data);
    $display("%s rd=%b wr=%b size=%0d addr=%h be=%b wb_data=%h wb_we=%b mis=%b",
             tag, op.rd, op.wr, op.size, op.alu, r.be, r.wb_data, r.wb_we, r.mis);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ex_ready_o), 32'h1);
    check({tag, "_req"}, 32'(data_req_o), 32'h0);
    check({tag, "_we"}, 32'(data_we_o), 32'h0);
    check({tag, "_be"}, 32'(data_be_o), 32'h0);
    check({tag, "_addr"}, data_addr_o, 32'h0);
    check({tag, "_wdata"}, data_wdata_o, 32'h0);
    check({tag, "_wb_valid"}, 32'(wb_valid_o), 32'h0);
    check({tag, "_wb_data"}, wb_data_o, 32'h0);
    check({tag, "_wb_waddr"}, 32'(wb_waddr_o), 32'h0);
    check({tag, "_wb_we"}, 32'(wb_we_o), 32'h0);
    check({tag, "_mis"}, 32'(misaligned_o), 32'h0);
  endtask

  // Starts a word load and parks it in the requested phase, then resets.
  task automatic reset_mid_txn(input string tag, input bit in_wait);
    int pulses;
    @(posedge clk_i); #1;
    drive_ex(mk_op(1, 0, 2'd2, 0, 32'h100, 0, 5'd5, 1, 0, 0, 0));
    ex_valid_i = 1'b1;
    @(posedge clk_i); #1;
    ex_valid_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_in_req"}, 32'(data_req_o), 32'h1);
    if (in_wait) begin
      data_gnt_i = 1'b1;
      @(negedge clk_i);
      data_gnt_i = 1'b0;
      check({tag, "_in_wait"}, 32'({data_req_o, ex_ready_o}), 32'h0);
    end
    #1 rst_i = 1'b1;
    #1 check_reset_outputs(tag);
    @(negedge clk_i);
    rst_i = 1'b0;
    data_rvalid_i = 1'b1; data_rdata_i = 32'hDEADBEEF;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      data_rvalid_i = 1'b0;
      if (wb_valid_o) pulses++;
    end
    check({tag, "_no_wb"}, pulses, 0);
    check({tag, "_idle_ready"}, 32'(ex_ready_o), 32'h1);
    check({tag, "_idle_req"}, 32'(data_req_o), 32'h0);
    $display("%s reset during %s, late rvalid ignored", tag, in_wait ? "WAIT_RVALID" : "REQ");
  endtask

  vec_t vecs[13];

  initial begin
    res_t r;
    op_t  op;

    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    res_t r;
    op_t  op;

    vecs[0]  = '{mk_op(1,0,2'd2,0,32'h100,32'h0,5'd3,1,2,0,32'hDEADBEEF),
                 mk_exp(1,32'h100,4'hF,32'h0,0,32'hDEADBEEF,1,0,1)};
    vecs[1]  = '{mk_op(0,1,2'd0,0,32'h203,32'h000000AB,5'd0,0,1,1,32'h0),
                 mk_exp(1,32'h200,4'h8,32'hABABABAB,1,32'h0,0,0,0)};
    vecs[2]  = '{mk_op(1,0,2'd1,0,32'h102,32'h0,5'd7,1,0,0,32'h80011234),
                 mk_exp(1,32'h100,4'hC,32'h0,0,32'hFFFF8001,1,0,1)};
    vecs[3]  = '{mk_op(1,0,2'd1,1,32'h102,32'h0,5'd7,1,0,0,32'h80011234),
                 mk_exp(1,32'h100,4'hC,32'h0,0,32'h00008001,1,0,1)};
    vecs[4]  = '{mk_op(1,0,2'd2,0,32'h101,32'h0,5'd2,1,0,0,32'h0),
                 mk_exp(0,32'h0,4'h0,32'h0,0,32'h0,0,1,0)};
    vecs[5]  = '{mk_op(0,1,2'd1,0,32'h40,32'hCAFE1236,5'd1,1,0,0,32'h0),
                 mk_exp(1,32'h40,4'h3,32'h12361236,1,32'h0,0,0,0)};
    vecs[6]  = '{mk_op(1,0,2'd0,0,32'h101,32'h0,5'd8,1,1,2,32'h11228033),
                 mk_exp(1,32'h100,4'h2,32'h0,0,32'hFFFFFF80,1,0,1)};
    vecs[7]  = '{mk_op(1,1,2'd3,0,32'h10,32'hFFFFFFFF,5'd9,1,0,1,32'h01234567),
                 mk_exp(1,32'h10,4'hF,32'h0,0,32'h01234567,1,0,1)};
    vecs[8]  = '{mk_op(1,0,2'd1,0,32'h103,32'h0,5'd4,1,0,0,32'h0),
                 mk_exp(0,32'h0,4'h0,32'h0,0,32'h0,0,1,0)};
    vecs[9]  = '{mk_op(1,0,2'd2,0,32'h20,32'h0,5'd0,1,0,0,32'h55),
                 mk_exp(1,32'h20,4'hF,32'h0,0,32'h55,0,0,1)};
    vecs[10] = '{mk_op(0,0,2'd0,0,32'h12345678,32'h0,5'd4,1,0,0,32'h0),
                 mk_exp(0,32'h0,4'h0,32'h0,0,32'h12345678,1,0,1)};
    vecs[11] = '{mk_op(1,0,2'd0,1,32'h303,32'h0,5'd6,1,0,0,32'hF0000000),
                 mk_exp(1,32'h300,4'h8,32'h0,0,32'h000000F0,1,0,1)};
    vecs[12] = '{mk_op(0,0,2'd2,0,32'h0BADF00D,32'h0,5'd4,0,0,0,32'h0),
                 mk_exp(0,32'h0,4'h0,32'h0,0,32'h0BADF00D,0,0,1)};

    // Asynchronous reset before any clock edge.
    #1 rst_i = 1'b1;
    #2 check_reset_outputs("reset");
    $display("reset outputs checked");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].op, r);
      compare($sformatf("vec%0d", i), vecs[i].op, vecs[i].e, r);
    end

    // Back-to-back ALU ops, rd=0 then rd=5.
    @(posedge clk_i); #1;
    drive_ex(mk_op(0, 0, 2'd0, 0, 32'h0000AAAA, 0, 5'd0, 1, 0, 0, 0));
    ex_valid_i = 1'b1;
    @(posedge clk_i); #1;
    drive_ex(mk_op(0, 0, 2'd0, 0, 32'h0000BBBB, 0, 5'd5, 1, 0, 0, 0));
    @(negedge clk_i);
    check("b2b_first_valid", 32'(wb_valid_o), 32'h1);
    check("b2b_first_data", wb_data_o, 32'h0000AAAA);
    check("b2b_first_we", 32'(wb_we_o), 32'h0);
    check("b2b_ready", 32'(ex_ready_o), 32'h1);
    @(posedge clk_i); #1;
    ex_valid_i = 1'b0;
    @(negedge clk_i);
    check("b2b_second_valid", 32'(wb_valid_o), 32'h1);
    check("b2b_second_data", wb_data_o, 32'h0000BBBB);
    check("b2b_second_we", 32'(wb_we_o), 32'h1);
    check("b2b_second_waddr", 32'(wb_waddr_o), 32'h5);
    @(negedge clk_i);
    check("b2b_pulse_end", 32'(wb_valid_o), 32'h0);
    $display("b2b two ALU ops retired on consecutive cycles");

    reset_mid_txn("rst_wait", 1'b1);
    reset_mid_txn("rst_req", 1'b0);

    // Randomised ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op.rd      = 1'($urandom_range(0, 1));
      op.wr      = 1'($urandom_range(0, 1));
      op.size    = 2'($urandom_range(0, 3));
      op.uns     = 1'($urandom_range(0, 1));
      op.alu     = $urandom();
      op.sdata   = $urandom();
      op.rd_addr = 5'($urandom_range(0, 31));
      op.we      = 1'($urandom_range(0, 1));
      op.gnt_dly = $urandom_range(0, 3);
      op.rv_dly  = $urandom_range(0, 3);
      op.rdata   = $urandom();
      run_op(op, r);
      compare($sformatf("rnd%0d", i), op, model(op), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
